// File: rtl/demux_reg.sv
// demux_reg: 1-to-4 registered stream demultiplexer.
// Ports: clk, rst (async high); in_valid/in_ready/in_data/in_sel from
//   one producer; out_valid/out_ready/out_data per lane (4 lanes);
//   acc_count counts accepted words modulo 2**CNT_W.
module demux_reg #(
   parameter int ancho = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ancho-1:0]   in_data,
   input  logic [1:0]         in_sel,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [4*ancho-1:0] out_data,
   output logic [CNT_W-1:0]   acc_count
);

   logic [3:0]         vld_q, vld_d;
   logic [4*ancho-1:0] data_q, data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               accept;

   // Only the addressed lane can stall the producer.
   assign in_ready = !rst & (!vld_q[in_sel] | out_ready[in_sel]);
   assign accept   = in_valid & in_ready;

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      for (int k = 0; k < 4; k++) begin
         if (accept && (in_sel == 2'(k))) begin
            vld_d[k]                 = 1'b1;
            data_d[k*ancho +: ancho] = in_data;
         end else if (out_ready[k]) begin
            // Draining an empty lane leaves it empty.
            vld_d[k] = 1'b0;
         end
      end
      if (accept) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_valid = vld_q;
   assign out_data  = data_q;
   assign acc_count = cnt_q;

endmodule

// File: tb/tb_demux_reg.sv
// tb_demux_reg: directed checks plus a scoreboarded 256-word run.
// Inputs change 1 time unit after the rising edge.
module tb_demux_reg;

   localparam int ancho = 4;
   localparam int CNT_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [ancho-1:0]   in_data;
   logic [1:0]         in_sel;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [4*ancho-1:0] out_data;
   logic [CNT_W-1:0]   acc_count;

   int n_chk = 0;
   int n_err = 0;

   demux_reg #(.ancho(ancho), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .acc_count (acc_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] lane(input int k);
      return out_data[k*ancho +: ancho];
   endfunction

   task automatic offer(input logic [1:0] s, input logic [3:0] d);
      in_valid = 1'b1;
      in_sel   = s;
      in_data  = d;
   endtask

   logic [3:0] q[4][$];
   logic [3:0] rdy;
   logic [1:0] s;
   logic [3:0] d;
   logic [3:0] mv;
   logic [3:0] w;
   int         acc;
   int         cyc;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      in_data   = 4'hF;
      out_ready = 4'b0000;
      step();
      step();
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data", 32'(out_data), 32'h0);
      check("rst_count", 32'(acc_count), 32'h0);
      check("rst_ready", 32'(in_ready), 32'h0);
      rst = 1'b0;

      // 1: single word to lane 2
      offer(2'd2, 4'hA);
      #1;
      check("t1_ready", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      check("t1_valid", 32'(out_valid), 32'h4);
      check("t1_lane2", 32'(lane(2)), 32'hA);
      check("t1_count", 32'(acc_count), 32'h1);

      // 2: blocked lane 1, other lane still accepted
      offer(2'd1, 4'h6);
      step();
      offer(2'd1, 4'h9);
      #1;
      check("t2_block", 32'(in_ready), 32'h0);
      step();
      check("t2_l1hold", 32'(lane(1)), 32'h6);
      check("t2_cnthold", 32'(acc_count), 32'h2);
      offer(2'd3, 4'h5);
      #1;
      check("t2_ready3", 32'(in_ready), 32'h1);
      step();
      check("t2_valid", 32'(out_valid), 32'hE);
      check("t2_lane3", 32'(lane(3)), 32'h5);
      check("t2_lane1", 32'(lane(1)), 32'h6);
      check("t2_count", 32'(acc_count), 32'h3);

      // 3: replace while draining, no bubble
      offer(2'd0, 4'h3);
      step();
      check("t3_fill", 32'(out_valid), 32'hF);
      offer(2'd0, 4'h7);
      out_ready = 4'b0001;
      #1;
      check("t3_ready", 32'(in_ready), 32'h1);
      step();
      check("t3_valid", 32'(out_valid), 32'hF);
      check("t3_lane0", 32'(lane(0)), 32'h7);
      check("t3_count", 32'(acc_count), 32'h5);

      // 4: drain all lanes, data words retained
      in_valid  = 1'b0;
      out_ready = 4'b1111;
      step();
      out_ready = 4'b0000;
      check("t4_valid", 32'(out_valid), 32'h0);
      check("t4_data", 32'(out_data), 32'h5A67);

      // 5: asynchronous reset mid-cycle
      offer(2'd0, 4'h8);
      step();
      offer(2'd3, 4'hC);
      step();
      check("t5_pre", 32'(out_valid), 32'h9);
      check("t5_precnt", 32'(acc_count), 32'h7);
      offer(2'd1, 4'h1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_valid", 32'(out_valid), 32'h0);
      check("t5_count", 32'(acc_count), 32'h0);
      check("t5_ready", 32'(in_ready), 32'h0);
      step();
      check("t5_noacc", 32'(acc_count), 32'h0);
      check("t5_novld", 32'(out_valid), 32'h0);
      rst      = 1'b0;
      in_valid = 1'b0;

      // 6: 256 accepts with per-lane ordering scoreboard
      acc = 0;
      cyc = 0;
      while (acc < 256 && cyc < 4000) begin
         s   = 2'($urandom_range(0, 3));
         d   = 4'($urandom);
         rdy = 4'($urandom);
         offer(s, d);
         out_ready = rdy;
         #1;
         for (int k = 0; k < 4; k++) begin
            mv[k] = (q[k].size() != 0);
         end
         check("t6_valid", 32'(out_valid), 32'(mv));
         check("t6_ready", 32'(in_ready), 32'(!mv[s] | rdy[s]));
         for (int k = 0; k < 4; k++) begin
            if (mv[k] && rdy[k]) begin
               w = q[k].pop_front();
               check("t6_order", 32'(lane(k)), 32'(w));
            end
         end
         if (!mv[s] || rdy[s]) begin
            q[s].push_back(d);
            acc++;
         end
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      check("t6_budget", 32'(acc), 32'd256);
      check("t6_wrap", 32'(acc_count), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
